pipe_stall_ctrl: RTL and testbench

//  Consumer side of the hazard-detection handshake. Takes hazard and redirect requests
//  (load-use stall from the HDU, taken branch/jump from ID, multi-cycle multiply/divide

---
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: turns load-use, taken-branch and multi-cycle
// MDU requests into per-stage write-enable, flush and bubble controls, plus stall/flush statistics.
module pipe_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             LoadUse_Hazard,
    input  logic             Branch_Taken,
    input  logic             MDU_Start,
    input  logic             Cnt_Clr,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             MDU_Busy,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam int DCNT_W = $clog2(MDU_LATENCY);
    // The start cycle itself is the first frozen cycle, so the stall state covers LATENCY-1.
    localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(MDU_LATENCY - 2);

    typedef enum logic {
        RUN       = 1'b0,
        MDU_STALL = 1'b1
    } state_t;

    state_t            state_reg;
    logic [DCNT_W-1:0] dcnt_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= RUN;
            dcnt_reg  <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (MDU_Start) begin
                        state_reg <= MDU_STALL;
                        dcnt_reg  <= DCNT_LOAD;
                    end
                end
                MDU_STALL: begin
                    if (dcnt_reg == '0) begin
                        state_reg <= RUN;
                    end else begin
                        dcnt_reg <= dcnt_reg - DCNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= RUN;
                    dcnt_reg  <= '0;
                end
            endcase
        end
    end

    // RUN responds in the same cycle; the reset term keeps every enable low while held.
    always_comb begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MDU_Busy     = 1'b0;
        if (Rst_n) begin
            case (state_reg)
                RUN: begin
                    if (MDU_Start) begin
                        PCWrite = 1'b0;
                    end else if (LoadUse_Hazard) begin
                        IDEX_Write  = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (Branch_Taken) begin
                        PCWrite    = 1'b1;
                        IFID_Write = 1'b1;
                        IFID_Flush = 1'b1;
                        IDEX_Write = 1'b1;
                    end else begin
                        PCWrite    = 1'b1;
                        IFID_Write = 1'b1;
                        IDEX_Write = 1'b1;
                    end
                end
                MDU_STALL: begin
                    EXMEM_Bubble = 1'b1;
                    MDU_Busy     = 1'b1;
                end
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

    // Index 0 counts frozen-PC cycles, index 1 counts IF/ID flush cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {IFID_Flush, ~PCWrite};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    cnt_reg <= '0;
                end else if (Cnt_Clr) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign Stall_Count = cnt_val[0];
    assign Flush_Count = cnt_val[1];

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a cycle-count reference model; two instances cover wide and 3-bit counters.
module tb_pipe_stall_ctrl;

    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic lu    = 1'b0;
    logic br    = 1'b0;
    logic md    = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    // Control vectors: {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, MDU_Busy}
    logic [6:0]  ctl_b, ctl_s;
    logic [15:0] sc_b, fc_b;
    logic [2:0]  sc_s, fc_s;

    pipe_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(16)) dut_big (
        .Clk(clk), .Rst_n(rst_n), .LoadUse_Hazard(lu), .Branch_Taken(br),
        .MDU_Start(md), .Cnt_Clr(clr),
        .PCWrite(ctl_b[6]), .IFID_Write(ctl_b[5]), .IFID_Flush(ctl_b[4]),
        .IDEX_Write(ctl_b[3]), .IDEX_Bubble(ctl_b[2]), .EXMEM_Bubble(ctl_b[1]),
        .MDU_Busy(ctl_b[0]), .Stall_Count(sc_b), .Flush_Count(fc_b)
    );

    pipe_stall_ctrl #(.MDU_LATENCY(LAT), .CNT_W(3)) dut_small (
        .Clk(clk), .Rst_n(rst_n), .LoadUse_Hazard(lu), .Branch_Taken(br),
        .MDU_Start(md), .Cnt_Clr(clr),
        .PCWrite(ctl_s[6]), .IFID_Write(ctl_s[5]), .IFID_Flush(ctl_s[4]),
        .IDEX_Write(ctl_s[3]), .IDEX_Bubble(ctl_s[2]), .EXMEM_Bubble(ctl_s[1]),
        .MDU_Busy(ctl_s[0]), .Stall_Count(sc_s), .Flush_Count(fc_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy_left = remaining frozen cycles after the MDU start cycle.
    int busy_left = 0;
    int m_sb = 0, m_fb = 0, m_ss = 0, m_fs = 0;

    function automatic logic [6:0] exp_ctl(input logic r, input int bl,
                                           input logic l, input logic b, input logic m);
        if (!r)     return 7'b0000000;
        if (bl > 0) return 7'b0000011;
        if (m)      return 7'b0000000;
        if (l)      return 7'b0001100;
        if (b)      return 7'b1111000;
        return 7'b1101000;
    endfunction

    function automatic int sat(input int v, input int cap);
        return (v >= cap) ? cap : v + 1;
    endfunction

    logic [6:0] e_now;
    assign e_now = exp_ctl(rst_n, busy_left, lu, br, md);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            m_sb <= 0; m_fb <= 0; m_ss <= 0; m_fs <= 0;
        end else begin
            if (clr) begin
                m_sb <= 0; m_fb <= 0; m_ss <= 0; m_fs <= 0;
            end else begin
                if (!e_now[6]) begin
                    m_sb <= sat(m_sb, 65535);
                    m_ss <= sat(m_ss, 7);
                end
                if (e_now[4]) begin
                    m_fb <= sat(m_fb, 65535);
                    m_fs <= sat(m_fs, 7);
                end
            end
            busy_left <= (busy_left > 0) ? busy_left - 1 : (md ? LAT - 1 : 0);
        end
    end

    always @(negedge clk) begin
        check("ctl_big", ctl_b, e_now);
        check("ctl_small", ctl_s, e_now);
        check("stall_cnt_big", sc_b, m_sb);
        check("flush_cnt_big", fc_b, m_fb);
        check("stall_cnt_small", sc_s, m_ss);
        check("flush_cnt_small", fc_s, m_fs);
        check("flush_without_write", ctl_b[4] & ~ctl_b[5], 1'b0);
    end

    task automatic drive(input logic l, input logic b, input logic m, input logic c);
        @(posedge clk);
        #2;
        lu = l; br = b; md = m; clr = c;
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held with random inputs
        repeat (3) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("t1_pc_in_reset", ctl_b[6], 1'b0);
        check("t1_stall_cnt_in_reset", sc_b, 16'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1; lu = 0; br = 0; md = 0; clr = 0;
        @(negedge clk);
        #1;
        check("t1_enables_after_release", {ctl_b[6], ctl_b[5], ctl_b[3]}, 3'b111);

        // Load-use
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        check("t2_pc_stalled", ctl_b[6], 1'b0);
        check("t2_idex_bubble", ctl_b[2], 1'b1);
        drive(0, 0, 0, 0);
        check("t2_normal_ctl", ctl_b, 7'b1101000);
        check("t2_stall_count", sc_b, 16'd1);

        // Load-use plus branch, then branch alone
        drive(0, 0, 0, 1);
        drive(1, 1, 0, 0);
        check("t3_no_flush_under_stall", ctl_b[4], 1'b0);
        check("t3_pc_stalled", ctl_b[6], 1'b0);
        drive(0, 1, 0, 0);
        check("t3_branch_flush", ctl_b[4], 1'b1);
        drive(0, 0, 0, 0);
        check("t3_flush_count", fc_b, 16'd1);
        check("t3_stall_count", sc_b, 16'd1);

        // MDU stall window with ignored hazards inside
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 0);
        check("t4_start_pc", ctl_b[6], 1'b0);
        check("t4_start_busy", ctl_b[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            check("t4_window_ctl", ctl_b, 7'b0000011);
        end
        drive(0, 0, 0, 0);
        check("t4_after_window_pc", ctl_b[6], 1'b1);
        check("t4_after_window_busy", ctl_b[0], 1'b0);
        check("t4_stall_count", sc_b, 16'd4);

        // Async reset one cycle into the stall
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("t5_busy_before_reset", ctl_b[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_on_reset", ctl_b[0], 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t5_run_after_release", ctl_b, 7'b1101000);

        // Saturation of the 3-bit counter, then clear beating a stall
        drive(0, 0, 0, 1);
        repeat (10) drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("t6_small_saturated", sc_s, 3'd7);
        check("t6_big_count", sc_b, 16'd10);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("t6_small_cleared", sc_s, 3'd0);
        check("t6_big_cleared", sc_b, 16'd0);

        // Randomized traffic
        repeat (3000) begin
            @(posedge clk);
            #2;
            rst_n = ($urandom_range(0, 399) != 0);
            lu    = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 3) == 0);
            md    = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1; lu = 0; br = 0; md = 0; clr = 0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
